// File: rtl/ctrl_pipeline_pkg.sv
// RV32I control-path types: opcodes, ALU ops, mux encodings, control word,
// per-stage control register and forwarding select, plus the forwarding test.
package ctrl_pipeline_pkg;

  localparam int RV_REG_W = 5;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'd0, alu_sll = 3'd1, alu_sra = 3'd2, alu_sub = 3'd3,
    alu_xor = 3'd4, alu_srl = 3'd5, alu_or  = 3'd6, alu_and = 3'd7
  } alu_ops;

  // branch funct3 codes reused as compare ops for slt/sltu
  localparam logic [2:0] CMP_BLT  = 3'b100;
  localparam logic [2:0] CMP_BLTU = 3'b110;

  // alumux1: 0 = rs1, 1 = pc
  localparam logic       A1_RS1 = 1'b0;
  localparam logic       A1_PC  = 1'b1;
  // alumux2 operand select
  localparam logic [2:0] A2_I_IMM = 3'd0;
  localparam logic [2:0] A2_U_IMM = 3'd1;
  localparam logic [2:0] A2_B_IMM = 3'd2;
  localparam logic [2:0] A2_S_IMM = 3'd3;
  localparam logic [2:0] A2_RS2   = 3'd4;
  localparam logic [2:0] A2_J_IMM = 3'd5;
  // memwb writeback select
  localparam logic [2:0] WB_ALU   = 3'd0;
  localparam logic [2:0] WB_BR_EN = 3'd1;
  localparam logic [2:0] WB_U_IMM = 3'd2;
  localparam logic [2:0] WB_LW    = 3'd3;
  localparam logic [2:0] WB_PC4   = 3'd4;

  typedef struct packed {
    rv32i_opcode opcode;
    alu_ops      aluop;
    logic [2:0]  cmpop;
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
    logic        alumux1_sel;
    logic [2:0]  alumux2_sel;
    logic        cmpmux_sel;
    logic [2:0]  memwbmux_sel;
    logic [2:0]  funct3;
    logic        muldiv;
    logic        illegal;
  } rv32i_control_word;

  typedef struct packed {
    logic                valid;
    logic [RV_REG_W-1:0] rs1;
    logic [RV_REG_W-1:0] rs2;
    logic [RV_REG_W-1:0] rd;
    rv32i_control_word   cword;
  } ctrl_stage_t;

  typedef enum logic [1:0] {
    fwd_rf  = 2'd0,
    fwd_mem = 2'd1,
    fwd_wb  = 2'd2
  } fwd_sel_t;

  // Nearest producer wins: MEM is younger than WB.
  function automatic fwd_sel_t fwd_pick(ctrl_stage_t mem, ctrl_stage_t wb,
                                        logic [RV_REG_W-1:0] rs);
    if (mem.valid && mem.cword.load_regfile && (mem.rd != '0) && (mem.rd == rs))
      return fwd_mem;
    if (wb.valid && wb.cword.load_regfile && (wb.rd != '0) && (wb.rd == rs))
      return fwd_wb;
    return fwd_rf;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ID-stage decoder: opcode/funct fields to control word, plus which source
// registers the instruction actually reads (for load-use detection).
module ctrl_decode
  import ctrl_pipeline_pkg::*;
#(
  parameter bit M_EXT = 1'b0
) (
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [RV_REG_W-1:0] rd,
  output rv32i_control_word   cword,
  output logic                uses_rs1,
  output logic                uses_rs2
);

  rv32i_opcode op;
  assign op = rv32i_opcode'(opcode);

  // opcode -> control word; unknown opcodes flag illegal with no side effects
  always_comb begin
    cword        = '0;
    cword.opcode = op;
    cword.funct3 = funct3;
    case (op)
      op_lui: begin
        cword.load_regfile = 1'b1;
        cword.memwbmux_sel = WB_U_IMM;
      end
      op_auipc: begin
        cword.load_regfile = 1'b1;
        cword.alumux1_sel  = A1_PC;
        cword.alumux2_sel  = A2_U_IMM;
      end
      op_jal: begin
        cword.load_regfile = 1'b1;
        cword.alumux1_sel  = A1_PC;
        cword.alumux2_sel  = A2_J_IMM;
        cword.memwbmux_sel = WB_PC4;
      end
      op_jalr: begin
        cword.load_regfile = 1'b1;
        cword.alumux1_sel  = A1_RS1;
        cword.alumux2_sel  = A2_I_IMM;
        cword.memwbmux_sel = WB_PC4;
      end
      op_br: begin
        cword.alumux1_sel = A1_PC;
        cword.alumux2_sel = A2_B_IMM;
        cword.cmpop       = funct3;
      end
      op_load: begin
        cword.load_regfile = 1'b1;
        cword.mem_read     = 1'b1;
        cword.alumux2_sel  = A2_I_IMM;
        cword.memwbmux_sel = WB_LW;
      end
      op_store: begin
        cword.mem_write   = 1'b1;
        cword.alumux2_sel = A2_S_IMM;
      end
      op_imm: begin
        cword.load_regfile = 1'b1;
        cword.alumux2_sel  = A2_I_IMM;
        case (funct3)
          3'b010: begin
            cword.cmpop = CMP_BLT;  cword.cmpmux_sel = 1'b1; cword.memwbmux_sel = WB_BR_EN;
          end
          3'b011: begin
            cword.cmpop = CMP_BLTU; cword.cmpmux_sel = 1'b1; cword.memwbmux_sel = WB_BR_EN;
          end
          3'b101:  cword.aluop = funct7[5] ? alu_sra : alu_srl;
          default: cword.aluop = alu_ops'(funct3);
        endcase
      end
      op_reg: begin
        cword.load_regfile = 1'b1;
        cword.alumux2_sel  = A2_RS2;
        cword.muldiv       = M_EXT && (funct7 == 7'b0000001);
        case (funct3)
          3'b000:  cword.aluop = funct7[5] ? alu_sub : alu_add;
          3'b010: begin cword.cmpop = CMP_BLT;  cword.memwbmux_sel = WB_BR_EN; end
          3'b011: begin cword.cmpop = CMP_BLTU; cword.memwbmux_sel = WB_BR_EN; end
          3'b101:  cword.aluop = funct7[5] ? alu_sra : alu_srl;
          default: cword.aluop = alu_ops'(funct3);
        endcase
      end
      default: cword.illegal = 1'b1;
    endcase
    // x0 is hardwired; never let a write to it look like a producer
    if (rd == '0) cword.load_regfile = 1'b0;
  end

  // source-register usage: lui/auipc/jal ignore rs1; only br/store/reg read rs2
  always_comb begin
    uses_rs1 = !(op inside {op_lui, op_auipc, op_jal});
    uses_rs2 = op inside {op_br, op_store, op_reg};
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control path for the 5-stage RV32I core: decodes ID, carries the control
// word through EX/MEM/WB, and resolves freeze, redirect, load-use and
// EX operand forwarding.
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
#(
  parameter bit M_EXT  = 1'b0,
  parameter int REG_W  = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_busy,
  input  logic             redirect,
  output logic             id_ready,
  output ctrl_stage_t      ex_ctrl,
  output ctrl_stage_t      mem_ctrl,
  output ctrl_stage_t      wb_ctrl,
  output fwd_sel_t         fwd_a_sel,
  output fwd_sel_t         fwd_b_sel
);

  ctrl_stage_t       ex_q, mem_q, wb_q, id_word, ex_d;
  rv32i_control_word id_cw;
  logic              uses_rs1, uses_rs2, load_use;

  ctrl_decode #(.M_EXT(M_EXT)) u_dec (
    .opcode   (id_opcode),
    .funct3   (id_funct3),
    .funct7   (id_funct7),
    .rd       (RV_REG_W'(id_rd)),
    .cword    (id_cw),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // assemble the ID stage word
  always_comb begin
    id_word       = '0;
    id_word.valid = id_valid;
    id_word.rs1   = RV_REG_W'(id_rs1);
    id_word.rs2   = RV_REG_W'(id_rs2);
    id_word.rd    = RV_REG_W'(id_rd);
    id_word.cword = id_cw;
  end

  // load in EX whose result a source of ID needs: one bubble is unavoidable
  always_comb begin
    load_use = ex_q.valid && ex_q.cword.mem_read && (ex_q.rd != '0) &&
               ((uses_rs1 && (ex_q.rd == id_word.rs1)) ||
                (uses_rs2 && (ex_q.rd == id_word.rs2)));
  end

  // advance priority: freeze > redirect > load-use > normal
  always_comb begin
    ex_d     = id_word;
    id_ready = 1'b1;
    if (mem_busy) begin
      id_ready = 1'b0;
    end else if (redirect) begin
      ex_d = '0;
    end else if (load_use) begin
      ex_d     = '0;
      id_ready = 1'b0;
    end
  end

  // stage registers; mem_busy holds everything in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_busy) begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // EX operand forwarding from registered MEM/WB state
  always_comb begin
    fwd_a_sel = fwd_rf;
    fwd_b_sel = fwd_rf;
    if (FWD_EN) begin
      fwd_a_sel = fwd_pick(mem_q, wb_q, ex_q.rs1);
      fwd_b_sel = fwd_pick(mem_q, wb_q, ex_q.rs2);
    end
  end

  assign ex_ctrl  = ex_q;
  assign mem_ctrl = mem_q;
  assign wb_ctrl  = wb_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboarded bench for ctrl_pipeline: each task drives ID and pushes the
// expected next EX word; the pipe expectation shifts EX->MEM->WB per clock.
module tb_ctrl_pipeline;
  import ctrl_pipeline_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, mem_busy, redirect;
  logic [6:0] id_opcode, id_funct7;
  logic [2:0] id_funct3;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic        id_ready, id_ready_m;
  ctrl_stage_t ex_ctrl, mem_ctrl, wb_ctrl, ex_m, mem_m, wb_m;
  fwd_sel_t    fa, fb, fa_m, fb_m;

  ctrl_pipeline #(.M_EXT(1'b0), .REG_W(5), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .mem_busy(mem_busy), .redirect(redirect), .id_ready(id_ready),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .fwd_a_sel(fa), .fwd_b_sel(fb));

  ctrl_pipeline #(.M_EXT(1'b1), .REG_W(5), .FWD_EN(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .mem_busy(mem_busy), .redirect(redirect), .id_ready(id_ready_m),
    .ex_ctrl(ex_m), .mem_ctrl(mem_m), .wb_ctrl(wb_m),
    .fwd_a_sel(fa_m), .fwd_b_sel(fb_m));

  typedef struct packed {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
  } instr_t;

  localparam instr_t IDLE   = '{op:7'h00, f3:3'd0, f7:7'd0, rs1:5'd0, rs2:5'd0, rd:5'd0};
  localparam instr_t ADDI1  = '{op:7'h13, f3:3'd0, f7:7'd0, rs1:5'd0, rs2:5'd5, rd:5'd1};
  localparam instr_t ADDI1B = '{op:7'h13, f3:3'd0, f7:7'd0, rs1:5'd0, rs2:5'd1, rd:5'd1};
  localparam instr_t ADD2   = '{op:7'h33, f3:3'd0, f7:7'd0, rs1:5'd1, rs2:5'd1, rd:5'd2};
  localparam instr_t LW3    = '{op:7'h03, f3:3'd2, f7:7'd0, rs1:5'd0, rs2:5'd0, rd:5'd3};
  localparam instr_t ADD4   = '{op:7'h33, f3:3'd0, f7:7'd0, rs1:5'd3, rs2:5'd0, rd:5'd4};
  localparam instr_t LW0    = '{op:7'h03, f3:3'd2, f7:7'd0, rs1:5'd0, rs2:5'd0, rd:5'd0};
  localparam instr_t ADD5   = '{op:7'h33, f3:3'd0, f7:7'd0, rs1:5'd0, rs2:5'd0, rd:5'd5};
  localparam instr_t LUI8   = '{op:7'h37, f3:3'd0, f7:7'd0, rs1:5'd3, rs2:5'd3, rd:5'd8};
  localparam instr_t SW3    = '{op:7'h23, f3:3'd2, f7:7'd0, rs1:5'd5, rs2:5'd3, rd:5'd0};
  localparam instr_t JAL1   = '{op:7'h6F, f3:3'd0, f7:7'd0, rs1:5'd0, rs2:5'd8, rd:5'd1};
  localparam instr_t ADDI9  = '{op:7'h13, f3:3'd0, f7:7'd0, rs1:5'd2, rs2:5'd3, rd:5'd9};
  localparam instr_t MUL6   = '{op:7'h33, f3:3'd0, f7:7'd1, rs1:5'd1, rs2:5'd2, rd:5'd6};
  localparam instr_t ILL    = '{op:7'h7F, f3:3'd0, f7:7'd0, rs1:5'd1, rs2:5'd2, rd:5'd5};

  int tests = 0;
  int fails = 0;
  ctrl_stage_t exq[$];
  ctrl_stage_t e_ex = '0, e_mem = '0, e_wb = '0;

  // reference decode written straight from the opcode table
  function automatic ctrl_stage_t ref_word(instr_t i, logic v, bit mext);
    ctrl_stage_t s;
    s = '0;
    s.valid = v; s.rs1 = i.rs1; s.rs2 = i.rs2; s.rd = i.rd;
    s.cword.opcode = rv32i_opcode'(i.op);
    s.cword.funct3 = i.f3;
    case (i.op)
      7'h37: begin s.cword.load_regfile = 1; s.cword.memwbmux_sel = 3'd2; end
      7'h17: begin s.cword.load_regfile = 1; s.cword.alumux1_sel = 1; s.cword.alumux2_sel = 3'd1; end
      7'h6F: begin s.cword.load_regfile = 1; s.cword.alumux1_sel = 1; s.cword.alumux2_sel = 3'd5;
                   s.cword.memwbmux_sel = 3'd4; end
      7'h67: begin s.cword.load_regfile = 1; s.cword.memwbmux_sel = 3'd4; end
      7'h63: begin s.cword.alumux1_sel = 1; s.cword.alumux2_sel = 3'd2; s.cword.cmpop = i.f3; end
      7'h03: begin s.cword.load_regfile = 1; s.cword.mem_read = 1; s.cword.memwbmux_sel = 3'd3; end
      7'h23: begin s.cword.mem_write = 1; s.cword.alumux2_sel = 3'd3; end
      7'h13: begin
        s.cword.load_regfile = 1;
        if (i.f3 == 3'd2) begin s.cword.cmpop = 3'd4; s.cword.cmpmux_sel = 1; s.cword.memwbmux_sel = 3'd1; end
        else if (i.f3 == 3'd3) begin s.cword.cmpop = 3'd6; s.cword.cmpmux_sel = 1; s.cword.memwbmux_sel = 3'd1; end
        else if (i.f3 == 3'd5) s.cword.aluop = i.f7[5] ? alu_sra : alu_srl;
        else s.cword.aluop = alu_ops'(i.f3);
      end
      7'h33: begin
        s.cword.load_regfile = 1; s.cword.alumux2_sel = 3'd4;
        s.cword.muldiv = mext && (i.f7 == 7'd1);
        if (i.f3 == 3'd0) s.cword.aluop = i.f7[5] ? alu_sub : alu_add;
        else if (i.f3 == 3'd2) begin s.cword.cmpop = 3'd4; s.cword.memwbmux_sel = 3'd1; end
        else if (i.f3 == 3'd3) begin s.cword.cmpop = 3'd6; s.cword.memwbmux_sel = 3'd1; end
        else if (i.f3 == 3'd5) s.cword.aluop = i.f7[5] ? alu_sra : alu_srl;
        else s.cword.aluop = alu_ops'(i.f3);
      end
      default: s.cword.illegal = 1;
    endcase
    if (i.rd == 5'd0) s.cword.load_regfile = 0;
    return s;
  endfunction

  // drive ID fields, then let combinational outputs settle
  task automatic drive(input instr_t i, input logic v);
    id_valid = v; id_opcode = i.op; id_funct3 = i.f3; id_funct7 = i.f7;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    #1;
  endtask

  // one clock; on an advancing edge pop the scoreboard into the EX slot
  task automatic cyc(input bit frz);
    @(posedge clk); #1;
    if (!frz) begin
      e_wb  = e_mem;
      e_mem = e_ex;
      e_ex  = (exq.size() != 0) ? exq.pop_front() : '0;
    end
  endtask

  task automatic test_reset();
    mem_busy = 0; redirect = 0;
    drive(IDLE, 0);
    #11;
    tests++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== '0) begin
      fails++; $display("FAIL reset_pipe: got %h %h %h want all zero", ex_ctrl, mem_ctrl, wb_ctrl);
    end
    tests++;
    if (id_ready !== 1'b1 || fa !== fwd_rf || fb !== fwd_rf) begin
      fails++; $display("FAIL reset_outs: got rdy=%b a=%0d b=%0d want 1 0 0", id_ready, fa, fb);
    end
    @(negedge clk) rst_n = 1;
    exq.push_back(ref_word(IDLE, 0, 0));
    cyc(0);
  endtask

  task automatic test_back_to_back();
    drive(ADDI1, 1); exq.push_back(ref_word(ADDI1, 1, 0));
    tests++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL b2b_rdy0: got %b want 1", id_ready); end
    cyc(0);
    drive(ADD2, 1); exq.push_back(ref_word(ADD2, 1, 0));
    tests++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== {e_ex, e_mem, e_wb}) begin
      fails++; $display("FAIL b2b_pipe1: got %h want %h", {ex_ctrl, mem_ctrl, wb_ctrl}, {e_ex, e_mem, e_wb});
    end
    cyc(0);
    drive(IDLE, 0); exq.push_back(ref_word(IDLE, 0, 0));
    tests++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== {e_ex, e_mem, e_wb}) begin
      fails++; $display("FAIL b2b_pipe2: got %h want %h", {ex_ctrl, mem_ctrl, wb_ctrl}, {e_ex, e_mem, e_wb});
    end
    tests++;
    if (fa !== fwd_mem || fb !== fwd_mem || id_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_fwd: got a=%0d b=%0d rdy=%b want 1 1 1", fa, fb, id_ready);
    end
    cyc(0);
  endtask

  task automatic test_load_use();
    drive(LW3, 1); exq.push_back(ref_word(LW3, 1, 0)); cyc(0);
    drive(ADD4, 1);
    tests++;
    if (id_ready !== 1'b0) begin fails++; $display("FAIL lu_stall: got rdy=%b want 0", id_ready); end
    exq.push_back('0); cyc(0);
    drive(ADD4, 1);
    tests++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL lu_release: got rdy=%b want 1", id_ready); end
    tests++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== {e_ex, e_mem, e_wb}) begin
      fails++; $display("FAIL lu_bubble: got %h want %h", {ex_ctrl, mem_ctrl, wb_ctrl}, {e_ex, e_mem, e_wb});
    end
    exq.push_back(ref_word(ADD4, 1, 0)); cyc(0);
    drive(IDLE, 0); exq.push_back(ref_word(IDLE, 0, 0));
    tests++;
    if (fa !== fwd_wb || fb !== fwd_rf) begin
      fails++; $display("FAIL lu_fwd: got a=%0d b=%0d want 2 0", fa, fb);
    end
    tests++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== {e_ex, e_mem, e_wb}) begin
      fails++; $display("FAIL lu_pipe: got %h want %h", {ex_ctrl, mem_ctrl, wb_ctrl}, {e_ex, e_mem, e_wb});
    end
    cyc(0);
    // lui carries x3 in its rs1 field but never reads it
    drive(LW3, 1); exq.push_back(ref_word(LW3, 1, 0)); cyc(0);
    drive(LUI8, 1);
    tests++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL lu_lui: got rdy=%b want 1", id_ready); end
    exq.push_back(ref_word(LUI8, 1, 0)); cyc(0);
  endtask

  task automatic test_redirect_loaduse();
    drive(LW3, 1); exq.push_back(ref_word(LW3, 1, 0)); cyc(0);
    drive(SW3, 1);
    tests++;
    if (id_ready !== 1'b0) begin fails++; $display("FAIL rl_store_rs2: got rdy=%b want 0", id_ready); end
    redirect = 1; #1;
    tests++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL rl_redirect_wins: got rdy=%b want 1", id_ready); end
    exq.push_back('0); cyc(0);
    redirect = 0;
    drive(IDLE, 0); exq.push_back(ref_word(IDLE, 0, 0));
    tests++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== {e_ex, e_mem, e_wb}) begin
      fails++; $display("FAIL rl_pipe: got %h want %h", {ex_ctrl, mem_ctrl, wb_ctrl}, {e_ex, e_mem, e_wb});
    end
    cyc(0);
  endtask

  task automatic test_rd_zero();
    drive(LW0, 1); exq.push_back(ref_word(LW0, 1, 0)); cyc(0);
    drive(ADD5, 1);
    tests++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL rd0_nostall: got rdy=%b want 1", id_ready); end
    exq.push_back(ref_word(ADD5, 1, 0)); cyc(0);
    drive(IDLE, 0); exq.push_back(ref_word(IDLE, 0, 0)); cyc(0);
    drive(IDLE, 0); exq.push_back(ref_word(IDLE, 0, 0));
    tests++;
    if (wb_ctrl.cword.load_regfile !== 1'b0 || wb_ctrl !== e_wb) begin
      fails++; $display("FAIL rd0_wb: got %h want %h", wb_ctrl, e_wb);
    end
    cyc(0);
  endtask

  task automatic test_redirect();
    drive(JAL1, 1); exq.push_back(ref_word(JAL1, 1, 0)); cyc(0);
    redirect = 1;
    drive(ADD2, 1);
    tests++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL jal_rdy: got rdy=%b want 1", id_ready); end
    exq.push_back('0); cyc(0);
    redirect = 0;
    drive(IDLE, 0); exq.push_back(ref_word(IDLE, 0, 0));
    tests++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== {e_ex, e_mem, e_wb}) begin
      fails++; $display("FAIL jal_pipe: got %h want %h", {ex_ctrl, mem_ctrl, wb_ctrl}, {e_ex, e_mem, e_wb});
    end
    tests++;
    if (mem_ctrl.cword.memwbmux_sel !== 3'd4 || ex_ctrl !== '0) begin
      fails++; $display("FAIL jal_wbsel: got sel=%0d ex=%h want 4 0", mem_ctrl.cword.memwbmux_sel, ex_ctrl);
    end
    cyc(0);
  endtask

  task automatic test_freeze();
    drive(ADDI1, 1);  exq.push_back(ref_word(ADDI1, 1, 0));  cyc(0);
    drive(ADDI1B, 1); exq.push_back(ref_word(ADDI1B, 1, 0)); cyc(0);
    drive(ADD2, 1);   exq.push_back(ref_word(ADD2, 1, 0));   cyc(0);
    mem_busy = 1;
    drive(ADDI9, 1);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({ex_ctrl, mem_ctrl, wb_ctrl} !== {e_ex, e_mem, e_wb} || id_ready !== 1'b0) begin
        fails++; $display("FAIL frz_hold%0d: got %h rdy=%b want %h rdy=0", k,
                          {ex_ctrl, mem_ctrl, wb_ctrl}, id_ready, {e_ex, e_mem, e_wb});
      end
      tests++;
      if (fa !== fwd_mem || fb !== fwd_mem) begin
        fails++; $display("FAIL frz_fwd%0d: got a=%0d b=%0d want 1 1", k, fa, fb);
      end
      cyc(1);
    end
    mem_busy = 0;
    drive(ADDI9, 1);
    tests++;
    if (id_ready !== 1'b1) begin fails++; $display("FAIL frz_resume_rdy: got %b want 1", id_ready); end
    exq.push_back(ref_word(ADDI9, 1, 0)); cyc(0);
    drive(IDLE, 0);
    tests++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== {e_ex, e_mem, e_wb} || fa !== fwd_mem || fb !== fwd_rf) begin
      fails++; $display("FAIL frz_resume: got %h a=%0d b=%0d want %h 1 0",
                        {ex_ctrl, mem_ctrl, wb_ctrl}, fa, fb, {e_ex, e_mem, e_wb});
    end
    // freeze beats a pending redirect
    mem_busy = 1; redirect = 1;
    drive(IDLE, 0);
    tests++;
    if (id_ready !== 1'b0) begin fails++; $display("FAIL frz_redir_rdy: got %b want 0", id_ready); end
    cyc(1);
    tests++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== {e_ex, e_mem, e_wb}) begin
      fails++; $display("FAIL frz_redir_hold: got %h want %h", {ex_ctrl, mem_ctrl, wb_ctrl}, {e_ex, e_mem, e_wb});
    end
    // reset during the freeze clears state without waiting for a clock
    rst_n = 0; #1;
    tests++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== '0 || fa !== fwd_rf || fb !== fwd_rf) begin
      fails++; $display("FAIL frz_reset: got %h a=%0d b=%0d want 0", {ex_ctrl, mem_ctrl, wb_ctrl}, fa, fb);
    end
    e_ex = '0; e_mem = '0; e_wb = '0; exq.delete();
    mem_busy = 0; redirect = 0;
    @(negedge clk) rst_n = 1;
    exq.push_back(ref_word(IDLE, 0, 0)); cyc(0);
  endtask

  task automatic test_mext();
    drive(MUL6, 1); exq.push_back(ref_word(MUL6, 1, 0)); cyc(0);
    drive(ILL, 1);
    tests++;
    if (ex_ctrl !== e_ex || ex_ctrl.cword.muldiv !== 1'b0) begin
      fails++; $display("FAIL mul_noext: got %h want %h", ex_ctrl, e_ex);
    end
    tests++;
    if (ex_m !== ref_word(MUL6, 1, 1) || ex_m.cword.muldiv !== 1'b1 || ex_m.cword.illegal !== 1'b0) begin
      fails++; $display("FAIL mul_ext: got %h want %h", ex_m, ref_word(MUL6, 1, 1));
    end
    exq.push_back(ref_word(ILL, 1, 0)); cyc(0);
    drive(IDLE, 0);
    tests++;
    if (ex_ctrl !== e_ex ||
        {ex_ctrl.cword.illegal, ex_ctrl.cword.load_regfile, ex_ctrl.cword.mem_read, ex_ctrl.cword.mem_write} !== 4'b1000) begin
      fails++; $display("FAIL illegal: got %h want %h", ex_ctrl, e_ex);
    end
    exq.push_back(ref_word(IDLE, 0, 0)); cyc(0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_redirect_loaduse();
    test_rd_zero();
    test_redirect();
    test_freeze();
    test_mext();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
